switch_port_buf: RTL and testbench
==================================

SWITCH_PORT_BUF -- requirements
Module: switch_port_buf

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the address field width.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the data field width.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of buffer entries; it SHALL be a power of two, 2 to 64.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_vld  input  1  SHALL be asserted when a routed entry from the switch output port is presented.
REQ-007 in_addr  input  ADDR_WIDTH  SHALL carry the address of the presented entry.
REQ-008 in_data  input  DATA_WIDTH  SHALL carry the data of the presented entry.
REQ-009 out_vld  output  1  SHALL be asserted when the head entry is available.
REQ-010 out_rdy  input  1  SHALL be asserted when the consumer accepts the head entry.
REQ-011 out_addr  output  ADDR_WIDTH  SHALL carry the head entry address.
REQ-012 out_data  output  DATA_WIDTH  SHALL carry the head entry data.
REQ-013 full  output  1  SHALL be high when count equals DEPTH.
REQ-014 empty  output  1  SHALL be high when count equals 0.
REQ-015 count  output  $clog2(DEPTH)+1  SHALL give the number of occupied entries.
REQ-016 drop_clr  input  1  SHALL synchronously clear drop_cnt.
REQ-017 drop_cnt  output  16  SHALL count entries discarded because of overflow.

Function
REQ-018 A push SHALL occur when in_vld=1 and either full=0 or a pop occurs in the same cycle.
REQ-019 A pop SHALL occur when out_vld=1 and out_rdy=1.
REQ-020 The buffer SHALL be first-in first-out.
REQ-021 out_vld SHALL equal !empty.
REQ-022 out_addr and out_data SHALL present the head entry directly (show-ahead), and SHALL be 0 while empty.
REQ-023 An entry pushed into an empty buffer SHALL appear on out_vld, out_addr and out_data in the next cycle (1-cycle latency); no bypass.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged, including at full.
REQ-025 A pop at count=1 with no push SHALL return to empty next cycle.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 When in_vld=1, full=1 and no pop occurs, the entry SHALL be discarded, buffer contents SHALL be unchanged, and drop_cnt SHALL increment by 1.
REQ-028 drop_cnt SHALL saturate at 16'hFFFF.
REQ-029 drop_clr SHALL have priority over a same-cycle increment; drop_cnt becomes 0.
REQ-030 out_rdy while empty SHALL have no effect.

Reset
REQ-031 On rstn=0, pointers, count and drop_cnt SHALL clear immediately, with no clock required.
REQ-032 During reset: out_vld=0, out_addr=0, out_data=0, empty=1, full=0.
REQ-033 Entries in flight at reset SHALL be lost.
REQ-034 Storage array contents need not be reset.
REQ-035 The first push SHALL be accepted on the first rising edge after rstn deasserts.

Structure
REQ-036 Shared package switch_pkg SHALL hold the ADDR_WIDTH and DATA_WIDTH defaults, the ADDR_DIV routing boundary, and a packed entry struct {addr, data} used by the switch and this buffer.
REQ-037 The saturating drop counter SHALL be the sub-module switch_sat_cnt (width parameter, inc, clr, value).
REQ-038 The FIFO storage and pointers SHALL stay inline.

Verification
REQ-039 Single entry: push addr=8'h12, data=16'hABCD into empty buffer with out_rdy=0 -> next cycle out_vld=1, out_addr=8'h12, out_data=16'hABCD, count=1.
REQ-040 Fill and overflow: push 5 entries (data 1..5) at DEPTH=4 with out_rdy=0 -> full=1, count=4, drop_cnt=1; drain yields data 1,2,3,4 in order, then empty=1.
REQ-041 At full, in_vld=1 and out_rdy=1 for 3 cycles -> count stays 4, drop_cnt unchanged, output order preserved across pointer wrap.
REQ-042 drop_cnt: force 65537 drops -> drop_cnt=16'hFFFF; drop_clr with a simultaneous drop -> drop_cnt=0.
REQ-043 Reset mid-operation: count=3, assert rstn=0 between clock edges -> out_vld=0, count=0 and drop_cnt=0 immediately; after release, a push appears one cycle later.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: default field widths, the address routing
// boundary and the entry format passed from the switch to its port buffers.
package switch_pkg;

    localparam int SW_ADDR_WIDTH = 8;
    localparam int SW_DATA_WIDTH = 16;

    // Addresses below ADDR_DIV route to port 0, the rest to port 1
    localparam logic [SW_ADDR_WIDTH-1:0] ADDR_DIV = 8'h80;

    typedef struct packed {
        logic [SW_ADDR_WIDTH-1:0] addr;
        logic [SW_DATA_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/switch_sat_cnt.sv
// Saturating event counter with a synchronous clear that beats a same-cycle
// increment; the counter itself resets asynchronously.
module switch_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= sat_inc(value);
        end
    end

endmodule

// File: rtl/switch_port_buf.sv
// Show-ahead output-port FIFO for the switch: accepts routed entries, drops
// and counts entries that arrive while full with no pop to make room.
module switch_port_buf
    import switch_pkg::*;
#(
    parameter int ADDR_WIDTH = SW_ADDR_WIDTH,
    parameter int DATA_WIDTH = SW_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_vld,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    drop_clr,
    output logic [15:0]             drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Same layout as switch_pkg::entry_t, but sized by this instance's widths
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } buf_entry_t;

    buf_entry_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            drop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign out_vld = !empty;

    // A pop frees a slot in the same cycle, so a full buffer can still accept
    assign pop  = out_vld && out_rdy;
    assign push = in_vld && (!full || pop);
    assign drop = in_vld && full && !pop;

    assign out_addr = empty ? '0 : mem[rd_ptr].addr;
    assign out_data = empty ? '0 : mem[rd_ptr].data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; empty gates what reaches the outputs
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_addr, in_data};
        end
    end

    switch_sat_cnt #(
        .WIDTH (16)
    ) u_drop_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (drop),
        .clr   (drop_clr),
        .value (drop_cnt)
    );

endmodule

// File: tb/tb_switch_port_buf.sv
// Directed bench for switch_port_buf: expected entries go into a scoreboard
// queue and a monitor compares them whenever the DUT pops its head entry.
module tb_switch_port_buf;

    logic        clk;
    logic        rstn;
    logic        in_vld;
    logic [7:0]  in_addr;
    logic [15:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_addr;
    logic [15:0] out_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        drop_clr;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [23:0] sb_q[$];

    switch_port_buf #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (in_vld),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_addr (out_addr),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return just after the rising edge
    task automatic step(input logic v, input logic [7:0] a, input logic [15:0] d,
                        input logic r, input logic c);
        in_vld   = v;
        in_addr  = a;
        in_data  = d;
        out_rdy  = r;
        drop_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [15:0] d, input logic r);
        sb_q.push_back({a, d});
        step(1'b1, a, d, r, 1'b0);
    endtask

    // Monitor: a pop happens on the next edge whenever out_vld and out_rdy are high
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && out_vld && out_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", {8'h0, out_addr, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [23:0] e;
                    e = sb_q.pop_front();
                    chk("pop_addr", {24'h0, out_addr}, {24'h0, e[23:16]});
                    chk("pop_data", {16'h0, out_data}, {16'h0, e[15:0]});
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; in_vld = 1'b0; in_addr = '0; in_data = '0;
        out_rdy = 1'b0; drop_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_vld", {31'h0, out_vld}, 32'h0);
        chk("rst_out_addr", {24'h0, out_addr}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
        #2 rstn = 1'b1;

        // Single entry, with no bypass into the same cycle
        sb_q.push_back({8'h12, 16'hABCD});
        in_vld = 1'b1; in_addr = 8'h12; in_data = 16'hABCD; out_rdy = 1'b0;
        #1;
        chk("no_bypass", {31'h0, out_vld}, 32'h0);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("single_vld", {31'h0, out_vld}, 32'h1);
        chk("single_addr", {24'h0, out_addr}, 32'h12);
        chk("single_data", {16'h0, out_data}, 32'hABCD);
        chk("single_count", {29'h0, count}, 32'h1);
        step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        chk("single_empty", {31'h0, empty}, 32'h1);

        // Fill and overflow: fifth entry is dropped
        for (int i = 1; i <= 4; i++) push_exp(8'h20 + 8'(i), 16'(i), 1'b0);
        step(1'b1, 8'h25, 16'h5, 1'b0, 1'b0);
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_count", {29'h0, count}, 32'h4);
        chk("fill_drop", {16'h0, drop_cnt}, 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        chk("drain_empty", {31'h0, empty}, 32'h1);
        chk("drain_addr0", {24'h0, out_addr}, 32'h0);
        step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        chk("rdy_empty_count", {29'h0, count}, 32'h0);

        // Simultaneous push and pop at full, across pointer wrap
        for (int i = 0; i < 4; i++) push_exp(8'h40 + 8'(i), 16'h0010 + 16'(i), 1'b0);
        for (int i = 4; i < 7; i++) begin
            push_exp(8'h40 + 8'(i), 16'h0010 + 16'(i), 1'b1);
            chk("pp_count", {29'h0, count}, 32'h4);
            chk("pp_drop", {16'h0, drop_cnt}, 32'h1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        chk("pp_empty", {31'h0, empty}, 32'h1);

        // Drop counter saturation and clear priority
        for (int i = 0; i < 4; i++) push_exp(8'h60 + 8'(i), 16'h0030 + 16'(i), 1'b0);
        step(1'b0, 8'h0, 16'h0, 1'b0, 1'b1);
        chk("clr_drop", {16'h0, drop_cnt}, 32'h0);
        for (int i = 0; i < 65534; i++) step(1'b1, 8'hEE, 16'hDEAD, 1'b0, 1'b0);
        chk("drop_fffe", {16'h0, drop_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 16'hDEAD, 1'b0, 1'b0);
        chk("drop_sat", {16'h0, drop_cnt}, 32'hFFFF);
        chk("drop_count", {29'h0, count}, 32'h4);
        step(1'b1, 8'hEE, 16'hDEAD, 1'b0, 1'b1);
        chk("clr_prio", {16'h0, drop_cnt}, 32'h0);
        step(1'b1, 8'hEE, 16'hDEAD, 1'b0, 1'b0);
        chk("drop_after_clr", {16'h0, drop_cnt}, 32'h1);

        // Reset mid-operation with three entries held
        step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        out_rdy = 1'b0;
        chk("pre_rst_count", {29'h0, count}, 32'h3);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_vld", {31'h0, out_vld}, 32'h0);
        chk("mid_rst_count", {29'h0, count}, 32'h0);
        chk("mid_rst_drop", {16'h0, drop_cnt}, 32'h0);
        chk("mid_rst_data", {16'h0, out_data}, 32'h0);
        sb_q.delete();
        @(posedge clk);
        #2 rstn = 1'b1;
        push_exp(8'h55, 16'h5A5A, 1'b0);
        in_vld = 1'b0;
        chk("post_rst_vld", {31'h0, out_vld}, 32'h1);
        chk("post_rst_data", {16'h0, out_data}, 32'h5A5A);
        chk("post_rst_count", {29'h0, count}, 32'h1);
        step(1'b0, 8'h0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 8'h0, 16'h0, 1'b0, 1'b0);

        chk("sb_leftover", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
